// File: rtl/mips_pkg.sv
// Shared pipeline definitions: forwarding selects, mul/div tracker states and register-match helper.
package mips_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // $0 is hardwired to zero, so it never carries a dependency.
    function automatic logic reg_match(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/md_tracker.sv
// Busy tracker for the iterative mul/div unit: IDLE -> BUSY (down-counter) -> DONE -> IDLE.
module md_tracker
    import mips_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mdstart_E,
    output logic md_busy,
    output logic md_in_busy
);

    localparam int unsigned MD_CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);

    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MD_IDLE;
            cnt_q      <= '0;
            md_busy    <= 1'b0;
            md_in_busy <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            md_busy    <= (state_d != MD_IDLE);
            md_in_busy <= (state_d == MD_BUSY);
        end
    end

    // A start seen in BUSY is ignored: decode already holds back further mul/div ops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (mdstart_E) begin
                    state_d = MD_BUSY;
                    cnt_d   = MD_LOAD;
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - MD_CNT_W'(1);
                if (cnt_q == MD_CNT_W'(1)) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                if (mdstart_E) begin
                    state_d = MD_BUSY;
                    cnt_d   = MD_LOAD;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the five-stage pipeline: forwarding selects, stalls, flush,
// branch gating and a saturating stalled-cycle counter.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs_D,
    input  logic [REG_W-1:0] rt_D,
    input  logic [REG_W-1:0] rs_E,
    input  logic [REG_W-1:0] rt_E,
    input  logic [REG_W-1:0] writereg_E,
    input  logic [REG_W-1:0] writereg_M,
    input  logic [REG_W-1:0] writereg_W,
    input  logic             regwrite_E,
    input  logic             regwrite_M,
    input  logic             regwrite_W,
    input  logic             memtoreg_E,
    input  logic             memtoreg_M,
    input  logic             branch_D,
    input  logic             mdstart_E,
    input  logic             mdread_D,
    input  logic             mdop_D,
    input  logic             pcsrc_raw_D,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_E,
    output logic             pcsrc_D,
    output logic             forwardA_D,
    output logic             forwardB_D,
    output logic [FWD_W-1:0] forwardA_E,
    output logic [FWD_W-1:0] forwardB_E,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    logic md_in_busy;
    logic lwstall, brstall, mdstall, stall_any;
    logic dep_E, dep_M;

    md_tracker #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .mdstart_E (mdstart_E),
        .md_busy   (md_busy),
        .md_in_busy(md_in_busy)
    );

    // Execute-stage operand selects; the younger M result wins over W.
    always_comb begin
        forwardA_E = FWD_RF;
        forwardB_E = FWD_RF;
        if (regwrite_M && reg_match(rs_E, writereg_M)) begin
            forwardA_E = FWD_MEM;
        end else if (regwrite_W && reg_match(rs_E, writereg_W)) begin
            forwardA_E = FWD_WB;
        end
        if (regwrite_M && reg_match(rt_E, writereg_M)) begin
            forwardB_E = FWD_MEM;
        end else if (regwrite_W && reg_match(rt_E, writereg_W)) begin
            forwardB_E = FWD_WB;
        end
    end

    // Stall causes are OR-ed; pcsrc is gated because IF/ID favours pcsrc over stall.
    always_comb begin
        forwardA_D = regwrite_M && reg_match(rs_D, writereg_M);
        forwardB_D = regwrite_M && reg_match(rt_D, writereg_M);
        dep_E      = reg_match(rs_D, writereg_E) || reg_match(rt_D, writereg_E);
        dep_M      = reg_match(rs_D, writereg_M) || reg_match(rt_D, writereg_M);
        lwstall    = memtoreg_E && dep_E;
        brstall    = branch_D && ((regwrite_E && dep_E) || (memtoreg_M && dep_M));
        mdstall    = md_in_busy && (mdread_D || mdop_D);
        stall_any  = lwstall || brstall || mdstall;
        stall_F    = stall_any;
        stall_D    = stall_any;
        flush_E    = stall_any;
        pcsrc_D    = pcsrc_raw_D && !stall_any;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_any && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed table, corner sequences, randomized vs. reference model.
module tb_hazard_ctrl;

    localparam int unsigned LAT  = 4;
    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [4:0] rs_D, rt_D, rs_E, rt_E, wr_E, wr_M, wr_W;
        logic rw_E, rw_M, rw_W, m2r_E, m2r_M;
        logic branch, mdstart, mdread, mdop, pcraw;
    } in_t;

    typedef struct packed {
        logic       stall, pcsrc, fad, fbd;
        logic [1:0] fae, fbe;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs_D, rt_D, rs_E, rt_E, writereg_E, writereg_M, writereg_W;
    logic regwrite_E, regwrite_M, regwrite_W, memtoreg_E, memtoreg_M;
    logic branch_D, mdstart_E, mdread_D, mdop_D, pcsrc_raw_D;
    logic stall_F, stall_D, flush_E, pcsrc_D, forwardA_D, forwardB_D, md_busy;
    logic [1:0] forwardA_E, forwardB_E;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    // Reference state: remaining BUSY cycles, a one-cycle DONE flag, and the stall tally.
    int busy_left = 0;
    bit done_ph   = 0;
    int m_cnt     = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
        .writereg_E(writereg_E), .writereg_M(writereg_M), .writereg_W(writereg_W),
        .regwrite_E(regwrite_E), .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
        .memtoreg_E(memtoreg_E), .memtoreg_M(memtoreg_M),
        .branch_D(branch_D), .mdstart_E(mdstart_E), .mdread_D(mdread_D), .mdop_D(mdop_D),
        .pcsrc_raw_D(pcsrc_raw_D),
        .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E), .pcsrc_D(pcsrc_D),
        .forwardA_D(forwardA_D), .forwardB_D(forwardB_D),
        .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 0) && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input in_t v);
        if (v.rw_M && hit(src, v.wr_M)) return 2'b10;
        if (v.rw_W && hit(src, v.wr_W)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model(input in_t v);
        exp_t e;
        bit uses_E, uses_M, st;
        uses_E = hit(v.rs_D, v.wr_E) || hit(v.rt_D, v.wr_E);
        uses_M = hit(v.rs_D, v.wr_M) || hit(v.rt_D, v.wr_M);
        st = (v.m2r_E && uses_E)
          || (v.branch && ((v.rw_E && uses_E) || (v.m2r_M && uses_M)))
          || ((busy_left > 0) && (v.mdread || v.mdop));
        e.stall = st;
        e.pcsrc = v.pcraw && !st;
        e.fad   = v.rw_M && hit(v.rs_D, v.wr_M);
        e.fbd   = v.rw_M && hit(v.rt_D, v.wr_M);
        e.fae   = fwd_sel(v.rs_E, v);
        e.fbe   = fwd_sel(v.rt_E, v);
        return e;
    endfunction

    function automatic exp_t mkexp(input bit s, input bit p, input bit a, input bit b,
                                   input logic [1:0] ae, input logic [1:0] be);
        exp_t e;
        e.stall = s; e.pcsrc = p; e.fad = a; e.fbd = b; e.fae = ae; e.fbe = be;
        return e;
    endfunction

    task automatic drive(input in_t v);
        rs_D = v.rs_D; rt_D = v.rt_D; rs_E = v.rs_E; rt_E = v.rt_E;
        writereg_E = v.wr_E; writereg_M = v.wr_M; writereg_W = v.wr_W;
        regwrite_E = v.rw_E; regwrite_M = v.rw_M; regwrite_W = v.rw_W;
        memtoreg_E = v.m2r_E; memtoreg_M = v.m2r_M;
        branch_D = v.branch; mdstart_E = v.mdstart; mdread_D = v.mdread;
        mdop_D = v.mdop; pcsrc_raw_D = v.pcraw;
    endtask

    task automatic cmp_exp(input string tag, input exp_t e);
        chk({tag, ".stall_F"}, 32'(stall_F), 32'(e.stall));
        chk({tag, ".stall_D"}, 32'(stall_D), 32'(e.stall));
        chk({tag, ".flush_E"}, 32'(flush_E), 32'(e.stall));
        chk({tag, ".pcsrc_D"}, 32'(pcsrc_D), 32'(e.pcsrc));
        chk({tag, ".fwdA_D"}, 32'(forwardA_D), 32'(e.fad));
        chk({tag, ".fwdB_D"}, 32'(forwardB_D), 32'(e.fbd));
        chk({tag, ".fwdA_E"}, 32'(forwardA_E), 32'(e.fae));
        chk({tag, ".fwdB_E"}, 32'(forwardB_E), 32'(e.fbe));
    endtask

    task automatic check_model(input string tag, input in_t v);
        cmp_exp(tag, model(v));
        chk({tag, ".md_busy"}, 32'(md_busy), 32'((busy_left > 0) || done_ph));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
    endtask

    // Advance one clock: update the reference on the edge, return at the next falling edge.
    task automatic tick(input in_t v);
        exp_t e;
        e = model(v);
        @(posedge clk);
        if (e.stall && m_cnt < CMAX) m_cnt++;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) done_ph = 1;
        end else begin
            done_ph = 0;
            if (v.mdstart) busy_left = LAT - 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_t z;
        z = '0;
        drive(z);
        rst_n = 1'b0;
        busy_left = 0; done_ph = 0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add(input in_t i, input exp_t e);
        vec_t x;
        x.i = i; x.e = e;
        vecs.push_back(x);
    endtask

    initial begin
        in_t t, z;
        z = '0;
        rst_n = 1'b0;
        drive(z);
        #2;
        cmp_exp("reset", mkexp(0, 0, 0, 0, 2'b00, 2'b00));
        chk("reset.md_busy", 32'(md_busy), 0);
        chk("reset.stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, all with the mul/div unit idle.
        add(z, mkexp(0, 0, 0, 0, 2'b00, 2'b00));
        t = z; t.m2r_E = 1; t.wr_E = 8; t.rs_D = 8;
        add(t, mkexp(1, 0, 0, 0, 2'b00, 2'b00));
        t = z; t.m2r_E = 1; t.wr_E = 0; t.rs_D = 8;
        add(t, mkexp(0, 0, 0, 0, 2'b00, 2'b00));
        t = z; t.rw_M = 1; t.wr_M = 9; t.rw_W = 1; t.wr_W = 9; t.rs_E = 9;
        add(t, mkexp(0, 0, 0, 0, 2'b10, 2'b00));
        t.rw_M = 0;
        add(t, mkexp(0, 0, 0, 0, 2'b01, 2'b00));
        t = z; t.branch = 1; t.rs_D = 4; t.rw_E = 1; t.wr_E = 4; t.pcraw = 1;
        add(t, mkexp(1, 0, 0, 0, 2'b00, 2'b00));
        t = z; t.branch = 1; t.rs_D = 4; t.rw_M = 1; t.wr_M = 4; t.pcraw = 1;
        add(t, mkexp(0, 1, 1, 0, 2'b00, 2'b00));
        t = z; t.rw_M = 1; t.wr_M = 5; t.rt_E = 5; t.rt_D = 5; t.rw_W = 1; t.wr_W = 7; t.rs_E = 7;
        add(t, mkexp(0, 0, 0, 1, 2'b01, 2'b10));
        t = z; t.rw_M = 1; t.wr_M = 0; t.rw_W = 1; t.wr_W = 0; t.m2r_E = 1; t.branch = 1; t.rw_E = 1;
        add(t, mkexp(0, 0, 0, 0, 2'b00, 2'b00));
        t = z; t.branch = 1; t.rt_D = 6; t.m2r_M = 1; t.rw_M = 1; t.wr_M = 6; t.pcraw = 1;
        add(t, mkexp(1, 0, 0, 1, 2'b00, 2'b00));
        t = z; t.rw_E = 1; t.wr_E = 3; t.rs_D = 3; t.pcraw = 1;
        add(t, mkexp(0, 1, 0, 0, 2'b00, 2'b00));

        foreach (vecs[k]) begin
            drive(vecs[k].i);
            #2;
            cmp_exp($sformatf("vec%0d", k), vecs[k].e);
            check_model($sformatf("vec%0d.m", k), vecs[k].i);
            tick(vecs[k].i);
        end

        // Load-use stall lasts one cycle and counts once.
        do_reset();
        t = z; t.m2r_E = 1; t.wr_E = 8; t.rs_D = 8;
        drive(t); #2;
        chk("lu.stall", 32'(stall_D), 1);
        chk("lu.cnt0", 32'(stall_cnt), 0);
        tick(t);
        drive(z); #2;
        chk("lu.nostall", 32'(stall_D), 0);
        chk("lu.cnt1", 32'(stall_cnt), 1);
        tick(z);

        // Mul/div window: start in cycle 0, reader held; stall in 1..3, DONE in 4, IDLE in 5.
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            t = z; t.mdread = 1; t.mdstart = (c == 0);
            drive(t); #2;
            chk($sformatf("md.c%0d.stall", c), 32'(stall_D), 32'((c >= 1) && (c <= 3)));
            chk($sformatf("md.c%0d.busy", c), 32'(md_busy), 32'((c >= 1) && (c <= 4)));
            check_model($sformatf("md.c%0d", c), t);
            tick(t);
        end

        // Back-to-back issue in DONE reloads straight into BUSY.
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            t = z; t.mdop = 1; t.mdstart = (c == 0) || (c == 4);
            drive(t); #2;
            chk($sformatf("b2b.c%0d.stall", c), 32'(stall_D), 32'((c >= 1 && c <= 3) || c >= 5));
            check_model($sformatf("b2b.c%0d", c), t);
            tick(t);
        end

        // Reset in BUSY aborts immediately.
        do_reset();
        t = z; t.mdstart = 1;
        drive(t); tick(t);
        t = z; t.mdread = 1;
        drive(t); tick(t);
        #2;
        chk("rmid.busy_before", 32'(md_busy), 1);
        chk("rmid.cnt_before", 32'(stall_cnt), 1);
        rst_n = 1'b0;
        #1;
        chk("rmid.busy", 32'(md_busy), 0);
        chk("rmid.cnt", 32'(stall_cnt), 0);
        chk("rmid.stall", 32'(stall_D), 0);
        do_reset();

        // Saturation of the stall counter.
        t = z; t.m2r_E = 1; t.wr_E = 2; t.rt_D = 2;
        for (int c = 0; c < 20; c++) begin
            drive(t); #2;
            check_model($sformatf("sat.c%0d", c), t);
            tick(t);
        end
        drive(z); #2;
        chk("sat.final", 32'(stall_cnt), CMAX);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            t.rs_D = 5'($urandom_range(0, 3)); t.rt_D = 5'($urandom_range(0, 3));
            t.rs_E = 5'($urandom_range(0, 3)); t.rt_E = 5'($urandom_range(0, 3));
            t.wr_E = 5'($urandom_range(0, 3)); t.wr_M = 5'($urandom_range(0, 3));
            t.wr_W = 5'($urandom_range(0, 3));
            t.rw_E = 1'($urandom_range(0, 1)); t.rw_M = 1'($urandom_range(0, 1));
            t.rw_W = 1'($urandom_range(0, 1)); t.m2r_E = 1'($urandom_range(0, 1));
            t.m2r_M = 1'($urandom_range(0, 1)); t.branch = 1'($urandom_range(0, 1));
            t.mdstart = ($urandom_range(0, 5) == 0); t.mdread = 1'($urandom_range(0, 1));
            t.mdop = ($urandom_range(0, 3) == 0); t.pcraw = 1'($urandom_range(0, 1));
            drive(t); #2;
            check_model($sformatf("rnd%0d", c), t);
            tick(t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
